// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared constants for the bit-serial subtractor: state encoding and default operand width.
package serial_subtractor_ctrl_pkg;

   typedef logic state_t;

   localparam state_t IDLE = 1'b0;
   localparam state_t RUN  = 1'b1;

   localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_ctrl_if.sv
// Start/busy/done handshake plus operand and result buses of the serial subtractor.
interface serial_subtractor_ctrl_if
   import serial_subtractor_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;

   modport master (
      output start, a, b,
      input  busy, done, diff, borrow_out
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, borrow_out
   );

endinterface

// File: rtl/serial_subtractor_ctrl_full_subtractor_bit.sv
// One-bit full subtractor built from two half subtractors and an OR of their borrows.
module half_subtractor (
   input  logic a,
   input  logic b,
   output logic d,
   output logic bout
);

   assign d    = a ^ b;
   assign bout = ~a & b;

endmodule

module full_subtractor_bit (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic d1;
   logic bout1;
   logic bout2;

   half_subtractor u_hs0 (
      .a    (a),
      .b    (b),
      .d    (d1),
      .bout (bout1)
   );

   // Second stage subtracts the incoming borrow from the first-stage difference.
   half_subtractor u_hs1 (
      .a    (d1),
      .b    (bin),
      .d    (d),
      .bout (bout2)
   );

   assign bout = bout1 | bout2;

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit unsigned subtractor: one bit per clock through a single full-subtractor cell.
module serial_subtractor_ctrl
   import serial_subtractor_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   serial_subtractor_ctrl_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   state_t             state_q;
   state_t             state_d;
   logic [WIDTH-1:0]   a_sr;
   logic [WIDTH-1:0]   b_sr;
   logic [WIDTH-1:0]   res_sr;
   logic [WIDTH-1:0]   res_next;
   logic               bin_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   diff_q;
   logic               borrow_q;
   logic               cell_d;
   logic               cell_bout;
   logic               accept_c;
   logic               step_c;
   logic               finish_c;

   full_subtractor_bit u_cell (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (bin_q),
      .d    (cell_d),
      .bout (cell_bout)
   );

   assign res_next = {cell_d, res_sr[WIDTH-1:1]};

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = RUN;
         RUN:     if (cnt_q == CNT_W'(WIDTH - 1)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Per-state control strobes for the datapath.
   always_comb begin
      accept_c = 1'b0;
      step_c   = 1'b0;
      finish_c = 1'b0;
      case (state_q)
         IDLE:    accept_c = bus.start;
         RUN: begin
            step_c   = 1'b1;
            finish_c = (cnt_q == CNT_W'(WIDTH - 1));
         end
         default: ;
      endcase
   end

   // Datapath and handshake registers; diff/borrow_out only move on completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr     <= '0;
         b_sr     <= '0;
         res_sr   <= '0;
         bin_q    <= 1'b0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else begin
         done_q <= finish_c;
         if (accept_c) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            bin_q  <= 1'b0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
         end else if (step_c) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_next;
            bin_q  <= cell_bout;
            cnt_q  <= finish_c ? '0 : cnt_q + CNT_W'(1);
            if (finish_c) begin
               diff_q   <= res_next;
               borrow_q <= cell_bout;
               busy_q   <= 1'b0;
            end
         end
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.diff       = diff_q;
   assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed self-checking bench for the bit-serial subtractor controller.
module tb_serial_subtractor_ctrl;

   localparam int unsigned W = 8;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   serial_subtractor_ctrl_if #(.WIDTH(W)) bus ();

   serial_subtractor_ctrl #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge: present operands with start, return at the falling edge after acceptance.
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_after_accept", 32'(bus.busy), 32'd1);
      check("done_after_accept", 32'(bus.done), 32'd0);
   endtask

   // Follows the remaining run cycles and checks the completion cycle.
   task automatic finish_op(input logic [W-1:0] prev, input logic [W-1:0] exp_d, input logic exp_b);
      for (int i = 1; i < int'(W); i++) begin
         @(negedge clk);
         check("busy_run", 32'(bus.busy), 32'd1);
         check("done_run", 32'(bus.done), 32'd0);
         check("diff_hold", 32'(bus.diff), 32'(prev));
      end
      @(negedge clk);
      check("busy_end", 32'(bus.busy), 32'd0);
      check("done_pulse", 32'(bus.done), 32'd1);
      check("diff", 32'(bus.diff), 32'(exp_d));
      check("borrow_out", 32'(bus.borrow_out), 32'(exp_b));
   endtask

   initial begin
      // Reset with start asserted and random operands: reset must win.
      rst       = 1'b1;
      bus.start = 1'b1;
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_diff", 32'(bus.diff), 32'd0);
      check("rst_borrow", 32'(bus.borrow_out), 32'd0);
      rst       = 1'b0;
      bus.start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("idle_done", 32'(bus.done), 32'd0);
         check("idle_busy", 32'(bus.busy), 32'd0);
      end

      // Basic subtraction and borrow cases.
      launch(8'd100, 8'd37);  finish_op(8'h00, 8'd63, 1'b0);
      @(negedge clk);
      check("done_one_cycle", 32'(bus.done), 32'd0);
      launch(8'd5, 8'd9);     finish_op(8'd63, 8'hFC, 1'b1);
      @(negedge clk);
      launch(8'h00, 8'h01);   finish_op(8'hFC, 8'hFF, 1'b1);
      @(negedge clk);
      launch(8'hFF, 8'hFF);   finish_op(8'hFF, 8'h00, 1'b0);
      @(negedge clk);

      // Start re-pulsed mid-run with new operands is ignored.
      launch(8'd50, 8'd20);
      @(negedge clk);
      @(negedge clk);
      bus.a     = 8'd1;
      bus.b     = 8'd2;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_ignore", 32'(bus.busy), 32'd1);
      for (int i = 4; i < int'(W); i++) begin
         @(negedge clk);
         check("done_ignore", 32'(bus.done), 32'd0);
         check("diff_ignore_hold", 32'(bus.diff), 32'd0);
      end
      @(negedge clk);
      check("done_ignore_pulse", 32'(bus.done), 32'd1);
      check("diff_ignore", 32'(bus.diff), 32'd30);
      check("borrow_ignore", 32'(bus.borrow_out), 32'd0);
      repeat (10) begin
         @(negedge clk);
         check("single_done", 32'(bus.done), 32'd0);
         check("no_relaunch", 32'(bus.busy), 32'd0);
      end

      // Reset mid-run aborts without a done pulse.
      launch(8'd200, 8'd100);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      check("abort_diff", 32'(bus.diff), 32'd0);
      check("abort_borrow", 32'(bus.borrow_out), 32'd0);
      repeat (12) begin
         @(negedge clk);
         check("abort_no_done", 32'(bus.done), 32'd0);
         check("abort_idle", 32'(bus.busy), 32'd0);
      end
      launch(8'd9, 8'd4);     finish_op(8'h00, 8'd5, 1'b0);
      @(negedge clk);

      // Back-to-back: new start presented during the done cycle.
      launch(8'd20, 8'd5);    finish_op(8'd5, 8'd15, 1'b0);
      launch(8'd10, 8'd3);    finish_op(8'd15, 8'd7, 1'b0);
      @(negedge clk);
      check("final_done_low", 32'(bus.done), 32'd0);
      check("final_diff_hold", 32'(bus.diff), 32'd7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
